// File: rtl/bounce_generator_pkg.sv
// bounce_generator_pkg: state encodings, LFSR constants and seed helpers for the bounce generator.
// rev 1.0
`default_nettype none

package bounce_generator_pkg;

   typedef enum logic [0:0] {
      ST_STABLE = 1'b0,
      ST_BOUNCE = 1'b1
   } bounce_state_t;

   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Taps for x^16 + x^14 + x^13 + x^11 + 1 as register bits 15, 13, 12, 10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // An all-zero LFSR never leaves zero, so a zero seed falls back to the default.
   function automatic logic [15:0] effective_seed(input logic [15:0] seed);
      return (seed == 16'h0000) ? DEFAULT_SEED : seed;
   endfunction

   function automatic logic lfsr_feedback(input logic [15:0] q);
      return ^(q & LFSR_TAPS);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bounce_generator_if.sv
// bounce_generator_if: clean-level inputs and bouncy outputs of the bounce generator.
// rev 1.0
`default_nettype none

interface bounce_generator_if #(
   parameter int WIDTH = 1
);
   logic             bounce_en;
   logic [WIDTH-1:0] clean_level;
   logic [WIDTH-1:0] glitchy_signal;
   logic [WIDTH-1:0] bouncing;

   modport master (
      output bounce_en,
      output clean_level,
      input  glitchy_signal,
      input  bouncing
   );

   modport slave (
      input  bounce_en,
      input  clean_level,
      output glitchy_signal,
      output bouncing
   );
endinterface

`default_nettype wire

// File: rtl/bounce_generator_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, shifts left every clock with feedback into bit 0.
// rev 1.0
`default_nettype none

module lfsr16
   import bounce_generator_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= seed;
      end else begin
         q <= {q[14:0], lfsr_feedback(q)};
      end
   end

endmodule

`default_nettype wire

// File: rtl/bounce_generator.sv
// bounce_generator: turns clean per-channel levels into deterministic chattering signals.
// rev 1.0
`default_nettype none

module bounce_generator
   import bounce_generator_pkg::*;
#(
   parameter int          WIDTH         = 1,
   parameter int          BOUNCE_CYCLES = 20,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   bounce_generator_if.slave bus
);

   localparam int          CNT_W    = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [15:0] SEED     = effective_seed(LFSR_SEED);

   logic [15:0]      lfsr_q;
   logic [WIDTH-1:0] glitchy_vec;
   logic [WIDTH-1:0] bouncing_vec;

   // Channels only sample the low WIDTH bits; the rest exist for the shift sequence.
   logic unused_lfsr_bits;
   assign unused_lfsr_bits = ^lfsr_q;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (SEED),
      .q     (lfsr_q)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      bounce_state_t    state;
      bounce_state_t    state_nxt;
      logic             settled;
      logic             settled_nxt;
      logic             target;
      logic             target_nxt;
      logic             glitchy;
      logic             glitchy_nxt;
      logic             bounce_q;
      logic             bounce_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             clean;

      assign clean = bus.clean_level[i];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state    <= ST_STABLE;
            settled  <= 1'b0;
            target   <= 1'b0;
            glitchy  <= 1'b0;
            bounce_q <= 1'b0;
            cnt      <= '0;
         end else begin
            state    <= state_nxt;
            settled  <= settled_nxt;
            target   <= target_nxt;
            glitchy  <= glitchy_nxt;
            bounce_q <= bounce_nxt;
            cnt      <= cnt_nxt;
         end
      end

      always_comb begin
         state_nxt   = state;
         settled_nxt = settled;
         target_nxt  = target;
         glitchy_nxt = glitchy;
         bounce_nxt  = bounce_q;
         cnt_nxt     = cnt;
         unique case (state)
            ST_STABLE: begin
               glitchy_nxt = settled;
               bounce_nxt  = 1'b0;
               if (clean != settled) begin
                  if (bus.bounce_en) begin
                     // The first chatter cycle already shows the new level.
                     state_nxt   = ST_BOUNCE;
                     target_nxt  = clean;
                     cnt_nxt     = CNT_LOAD;
                     glitchy_nxt = clean;
                     bounce_nxt  = 1'b1;
                  end else begin
                     settled_nxt = clean;
                     glitchy_nxt = clean;
                  end
               end
            end
            ST_BOUNCE: begin
               bounce_nxt = 1'b1;
               if (clean != target) begin
                  // A fresh edge restarts the window, even on the cycle it would settle.
                  target_nxt  = clean;
                  cnt_nxt     = CNT_LOAD;
                  glitchy_nxt = lfsr_q[i];
               end else if (cnt == '0) begin
                  state_nxt   = ST_STABLE;
                  settled_nxt = target;
                  glitchy_nxt = target;
                  bounce_nxt  = 1'b0;
               end else begin
                  cnt_nxt     = cnt - CNT_W'(1);
                  glitchy_nxt = lfsr_q[i];
               end
            end
            default: begin
               state_nxt = ST_STABLE;
            end
         endcase
      end

      assign glitchy_vec[i]  = glitchy;
      assign bouncing_vec[i] = bounce_q;
   end

   assign bus.glitchy_signal = glitchy_vec;
   assign bus.bouncing       = bouncing_vec;

endmodule

`default_nettype wire

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: two 4-channel generators (seed 0 -> ACE1, seed 1) against a timing reference model.
// rev 1.0
`default_nettype none

module tb_bounce_generator;

   localparam int W  = 4;
   localparam int BC = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic         en;
   logic [W-1:0] clean;

   always #5 clk = ~clk;

   bounce_generator_if #(.WIDTH(W)) bus0 ();
   bounce_generator_if #(.WIDTH(W)) bus1 ();

   assign bus0.bounce_en   = en;
   assign bus0.clean_level = clean;
   assign bus1.bounce_en   = en;
   assign bus1.clean_level = clean;

   bounce_generator #(.WIDTH(W), .BOUNCE_CYCLES(BC), .LFSR_SEED(16'h0000)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   bounce_generator #(.WIDTH(W), .BOUNCE_CYCLES(BC), .LFSR_SEED(16'h0001)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: each channel remembers its output level and when its chatter window began.
   typedef struct {
      logic [W-1:0] g0;
      logic [W-1:0] b0;
      logic [W-1:0] g1;
      logic [W-1:0] b1;
   } exp_t;

   exp_t        expq[$];
   logic [15:0] m_seed [2] = '{16'hACE1, 16'h0001};
   logic [15:0] m_lfsr [2];
   bit          m_lv   [2][W];
   bit          m_tgt  [2][W];
   bit          m_win  [2][W];
   int          m_start[2][W];
   int          m_k;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk) begin : model
      exp_t         e;
      logic [W-1:0] g [2];
      logic [W-1:0] b [2];
      bit           cl;
      bit           gv;
      if (!rst_n) begin
         for (int n = 0; n < 2; n++) begin
            m_lfsr[n] = m_seed[n];
            g[n] = '0;
            b[n] = '0;
            for (int c = 0; c < W; c++) begin
               m_lv[n][c]  = 1'b0;
               m_tgt[n][c] = 1'b0;
               m_win[n][c] = 1'b0;
               m_start[n][c] = 0;
            end
         end
         m_k = 0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < W; c++) begin
               cl = clean[c];
               if (m_win[n][c]) begin
                  if (cl != m_tgt[n][c]) begin
                     m_tgt[n][c]   = cl;
                     m_start[n][c] = m_k;
                     gv = m_lfsr[n][c];
                  end else if (m_k - m_start[n][c] == BC) begin
                     m_win[n][c] = 1'b0;
                     m_lv[n][c]  = m_tgt[n][c];
                     gv = m_tgt[n][c];
                  end else begin
                     gv = m_lfsr[n][c];
                  end
               end else if (cl != m_lv[n][c]) begin
                  if (en) begin
                     m_win[n][c]   = 1'b1;
                     m_tgt[n][c]   = cl;
                     m_start[n][c] = m_k;
                  end else begin
                     m_lv[n][c] = cl;
                  end
                  gv = cl;
               end else begin
                  gv = m_lv[n][c];
               end
               g[n][c] = gv;
               b[n][c] = m_win[n][c];
            end
            m_lfsr[n] = lfsr_next(m_lfsr[n]);
         end
         m_k++;
      end
      e.g0 = g[0];
      e.b0 = b[0];
      e.g1 = g[1];
      e.b1 = b[1];
      expq.push_back(e);
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         check("dut0_glitchy",  16'(bus0.glitchy_signal), 16'(e.g0));
         check("dut0_bouncing", 16'(bus0.bouncing),       16'(e.b0));
         check("dut1_glitchy",  16'(bus1.glitchy_signal), 16'(e.g1));
         check("dut1_bouncing", 16'(bus1.bouncing),       16'(e.b1));
      end
   end

   int bcnt = 0;
   always begin
      @(posedge clk);
      #1;
      if (bus0.bouncing[0] === 1'b1) bcnt++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int base;
      en    = 1'b1;
      clean = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         clean = W'($urandom);
      end
      @(negedge clk);
      clean = '0;
      rst_n = 1'b1;
      step(2);

      // Single rising edge on ch0.
      base  = bcnt;
      clean = 4'b0001;
      step(30);
      check("ch0_window_len", 16'(bcnt - base), 16'd20);

      // Pass-through mode.
      en    = 1'b0;
      base  = bcnt;
      clean = 4'b0000;
      step(3);
      clean = 4'b0001;
      step(3);
      clean = 4'b0000;
      step(3);
      check("bypass_no_bounce", 16'(bcnt - base), 16'd0);

      // Retrigger after 8 cycles.
      en    = 1'b1;
      base  = bcnt;
      clean = 4'b0001;
      step(8);
      clean = 4'b0000;
      step(40);
      check("retrigger_len", 16'(bcnt - base), 16'd28);

      // Simultaneous ch0/ch3, then ch1 five cycles later.
      clean = 4'b1001;
      step(5);
      clean = 4'b1011;
      step(30);

      // Change arriving on the cycle the window would settle.
      base  = bcnt;
      clean = 4'b1010;
      step(20);
      clean = 4'b1011;
      step(45);
      check("restart_at_zero_len", 16'(bcnt - base), 16'd40);

      // bounce_en dropped mid-window, then a bypassed change.
      clean = 4'b1001;
      step(5);
      en = 1'b0;
      step(25);
      clean = 4'b1000;
      step(4);
      en = 1'b1;

      // Asynchronous reset in the middle of a window.
      clean = 4'b0110;
      step(7);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_glitchy0",  16'(bus0.glitchy_signal), 16'd0);
      check("async_rst_bouncing0", 16'(bus0.bouncing),       16'd0);
      check("async_rst_glitchy1",  16'(bus1.glitchy_signal), 16'd0);
      check("async_rst_bouncing1", 16'(bus1.bouncing),       16'd0);
      step(2);
      rst_n = 1'b1;
      step(25);

      // Random traffic.
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) clean = clean ^ W'(1 << $urandom_range(0, W - 1));
         if ($urandom_range(0, 63) == 0) en = ~en;
      end
      en = 1'b1;
      step(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
